// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-precision CLA adder sequencer:
// word width, FSM state type and word-index width helper.
package cla_seq_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla64bit.sv
// 64-bit carry-lookahead adder: 4-bit groups, group generate/propagate
// drives the group carries, bit carries are resolved inside each group.
module cla64bit (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] g, p;
  logic [64:0] c;
  logic [16:0] cg;
  logic [15:0] gg, gp;

  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) |
              (p[4*i+3] & p[4*i+2] & g[4*i+1]) |
              (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    cg[0] = cin;
    for (int unsigned i = 0; i < 16; i++) begin
      cg[i+1] = gg[i] | (gp[i] & cg[i]);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      c[4*i] = cg[i];
      for (int unsigned j = 1; j < 4; j++) begin
        c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
      end
    end
    c[64] = cg[16];
    sum   = p ^ c[63:0];
    cout  = c[64];
  end

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-precision adder: one shared cla64bit, one word per clock, LSW first.
// Optional subtract mode enabled by defining CLA_SEQ_SUB_EN.
module cla_wide_add_seq
  import cla_seq_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   in_a,
  input  logic [WORD_W*NUM_WORDS-1:0]   in_b,
  input  logic                          in_cin,
  input  logic                          in_sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W*NUM_WORDS-1:0]   out_sum,
  output logic                          out_cout
);

  localparam int unsigned     WIDTH = WORD_W * NUM_WORDS;
  localparam int unsigned     IDXW  = idx_width(NUM_WORDS);
  localparam logic [IDXW-1:0] LAST  = IDXW'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q;
  logic [IDXW-1:0]   idx;
  logic [WORD_W-1:0] wa, wb, ws;
  logic              wc;

  assign wa = a_q[idx*WORD_W +: WORD_W];
  assign wb = b_q[idx*WORD_W +: WORD_W];

  cla64bit u_cla (
    .A    (wa),
    .B    (wb),
    .cin  (carry_q),
    .sum  (ws),
    .cout (wc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifndef CLA_SEQ_SUB_EN
  logic unused_sub;
  assign unused_sub = in_sub;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= in_a;
`ifdef CLA_SEQ_SUB_EN
      // Two's-complement subtract: invert B once at latch time, force carry-in.
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub ? 1'b1 : in_cin;
`else
      b_q     <= in_b;
      carry_q <= in_cin;
`endif
      idx     <= '0;
      sum_q   <= '0;
    end else if (state == RUN) begin
      sum_q[idx*WORD_W +: WORD_W] <= ws;
      carry_q <= wc;
      idx     <= idx + 1'b1;
      if (idx == LAST) cout_q <= wc;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Bench for cla_wide_add_seq: directed table, handshake corner sequences and
// random vectors against a plain-arithmetic reference (NUM_WORDS=2 and 1).
module tb_cla_wide_add_seq;

  localparam int unsigned NW = 2;
  localparam int unsigned W  = 64 * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
  logic [W-1:0]  in_a, in_b, out_sum;

  logic          v1_in_valid, v1_in_ready, v1_in_cin, v1_in_sub;
  logic          v1_out_valid, v1_out_ready, v1_out_cout;
  logic [63:0]   v1_in_a, v1_in_b, v1_out_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_wide_add_seq #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  cla_wide_add_seq #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .in_a(v1_in_a), .in_b(v1_in_b), .in_cin(v1_in_cin), .in_sub(v1_in_sub),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready),
    .out_sum(v1_out_sum), .out_cout(v1_out_cout)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  // Reference: full-width integer arithmetic with one extra carry bit.
  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin, sub);
    logic eff_sub;
`ifdef CLA_SEQ_SUB_EN
    eff_sub = sub;
`else
    eff_sub = 1'b0;
`endif
    if (eff_sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[32*i +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0: r = '1;
      1: r = '0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec);
    int  lat = 0;
    bit  rdy_seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, W'(lat), W'(NW));
    chk({nm, "_rdy_busy"}, W'(rdy_seen | in_ready), '0);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_cout"}, W'(out_cout), W'(ec));
  endtask

  task automatic release_result(input string nm);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_hs_valid"}, W'(out_valid), '0);
    chk({nm, "_hs_ready"}, W'(in_ready), W'(1));
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic run_txn(input string nm, input logic [W-1:0] a, b, input logic cin, sub,
                         input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    chk({nm, "_ready_before"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin;
    wait_result(nm, es, ec);
    release_result(nm);
  endtask

  task automatic run1(input string nm, input logic [63:0] a, b, input logic cin,
                      input logic [63:0] es, input logic ec);
    int lat = 0;
    @(negedge clk);
    v1_in_a = a; v1_in_b = b; v1_in_cin = cin; v1_in_sub = 1'b0; v1_in_valid = 1'b1;
    @(posedge clk); #1;
    v1_in_valid = 1'b0;
    while (!v1_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, W'(lat), W'(1));
    chk({nm, "_sum"}, W'(v1_out_sum), W'(es));
    chk({nm, "_cout"}, W'(v1_out_cout), W'(ec));
    @(negedge clk); v1_out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_hs_ready"}, W'(v1_in_ready), W'(1));
    @(negedge clk); v1_out_ready = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    logic [W-1:0] a, b, s0;
    logic         c0, cin, sub;
    logic [W:0]   m;

    tbl[0] = '{a: W'(1), b: W'(1), cin: 1'b0, sub: 1'b0, exp_sum: W'(2), exp_cout: 1'b0};
    tbl[1] = '{a: {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, b: W'(1), cin: 1'b0, sub: 1'b0,
               exp_sum: {64'h1, 64'h0}, exp_cout: 1'b0};
    tbl[2] = '{a: '1, b: W'(1), cin: 1'b0, sub: 1'b0, exp_sum: '0, exp_cout: 1'b1};
    tbl[3] = '{a: '0, b: '0, cin: 1'b1, sub: 1'b0, exp_sum: W'(1), exp_cout: 1'b0};
`ifdef CLA_SEQ_SUB_EN
    tbl[4] = '{a: W'(5), b: W'(7), cin: 1'b0, sub: 1'b1, exp_sum: {{(W-2){1'b1}}, 2'b10}, exp_cout: 1'b0};
    tbl[5] = '{a: W'(7), b: W'(5), cin: 1'b1, sub: 1'b1, exp_sum: W'(2), exp_cout: 1'b1};
`else
    tbl[4] = '{a: W'(5), b: W'(7), cin: 1'b0, sub: 1'b1, exp_sum: W'(12), exp_cout: 1'b0};
    tbl[5] = '{a: W'(7), b: W'(5), cin: 1'b1, sub: 1'b1, exp_sum: W'(13), exp_cout: 1'b0};
`endif

    rst_n = 1'b0;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 0;
    v1_in_valid = 0; v1_in_a = '0; v1_in_b = '0; v1_in_cin = 0; v1_in_sub = 0; v1_out_ready = 0;
    #12;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_cout", W'(out_cout), '0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
              tbl[i].exp_sum, tbl[i].exp_cout);

    // Backpressure in DONE with a competing request on the input side.
    @(negedge clk);
    in_a = {64'h1234, 64'hFFFF_FFFF_FFFF_FFF0}; in_b = W'(32); in_cin = 0; in_sub = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_first", {64'h1235, 64'h10}, 1'b0);
    s0 = out_sum; c0 = out_cout;
    @(negedge clk);
    in_a = W'(100); in_b = W'(23); in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", out_sum, s0);
      chk("bp_hold_cout", W'(out_cout), W'(c0));
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_ready", W'(in_ready), '0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", W'(out_valid), '0);
    chk("bp_rel_ready", W'(in_ready), W'(1));
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_second", W'(124), 1'b0);
    release_result("bp_second");

    // Reset while in RUN after the first word has been written.
    @(negedge clk);
    in_a = '1; in_b = '1; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstrun_valid", W'(out_valid), '0);
    chk("rstrun_sum", out_sum, '0);
    chk("rstrun_ready", W'(in_ready), W'(1));
    @(negedge clk); rst_n = 1'b1;
    run_txn("after_rst", {64'h0, 64'h8000_0000_0000_0000}, {64'h0, 64'h8000_0000_0000_0000},
            1'b0, 1'b0, {64'h1, 64'h0}, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom);
      m = model(a, b, cin, sub);
      run_txn($sformatf("rnd%0d", i), a, b, cin, sub, m[W-1:0], m[W]);
    end

    run1("nw1_add", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0);
    run1("nw1_ovf", '1, 64'd1, 1'b0, 64'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
